// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Holds the FSM state enum, op enum, width and counter-width constants.
package multdiv_pkg;

  localparam int MULTDIV_WIDTH = 32;
  localparam int MULTDIV_CNT_W = $clog2(MULTDIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the magnitude datapath: conditional add and shift for
// multiply, or shift and trial subtract/restore for restoring divide.
// Ports: op_i selects the operation; acc_i/mcand_i/b_i are the current
//   accumulator, shifted multiplicand and multiplier/divisor; the *_o
//   ports are their values after one step.
// For divide, acc holds {remainder, quotient-in-progress}.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
) (
  input  op_e                  op_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [2*WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [2*WIDTH-1:0]   mcand_o,
  output logic [WIDTH-1:0]     b_o
);

  // Remainder shifted left with the next dividend bit, minus divisor.
  // One extra bit keeps the borrow visible.
  logic [WIDTH:0] trial;

  always_comb begin
    acc_o   = acc_i;
    mcand_o = mcand_i;
    b_o     = b_i;
    trial   = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, b_i};
    unique case (op_i)
      OP_MULT: begin
        if (b_i[0]) acc_o = acc_i + mcand_i;
        mcand_o = {mcand_i[2*WIDTH-2:0], 1'b0};
        b_o     = {1'b0, b_i[WIDTH-1:1]};
      end
      OP_DIV: begin
        if (!trial[WIDTH])
          acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        else
          acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply / divide sequencer for the execute stage.
// Ports: clock, reset_n (async active-low); ctrl_MULT/ctrl_DIV start
//   pulses; data_operandA/B operands; data_result, data_exception and
//   the one-cycle data_resultRDY pulse; busy stalls the pipeline.
// Build option MULTDIV_EARLY_TERM_EN: multiply stops once |B| is consumed.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;

  logic [2*WIDTH-1:0] step_acc, step_mcand;
  logic [WIDTH-1:0]   step_b;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   fix_res;
  logic               fix_exc;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .b_i     (b_q),
    .acc_o   (step_acc),
    .mcand_o (step_mcand),
    .b_o     (step_b)
  );

  assign a_abs = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_abs = b_q[WIDTH-1] ? -b_q : b_q;

  // Sign correction and exception detection.
  always_comb begin
    prod    = sign_q ? -acc_q : acc_q;
    quo     = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_res = '0;
    fix_exc = 1'b0;
    if (op_q == OP_MULT) begin
      fix_res = prod[WIDTH-1:0];
      // Fits only if the upper half is a sign extension of bit W-1.
      fix_exc = !((&prod[2*WIDTH-1:WIDTH-1]) ||
                  !(|prod[2*WIDTH-1:WIDTH-1]));
    end else if (dz_q) begin
      fix_res = '0;
      fix_exc = 1'b1;
    end else begin
      fix_res = quo;
      // A positive quotient with the top bit set is only -2^(W-1)/-1.
      fix_exc = !sign_q && acc_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    res_d   = res_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_MULT ^ ctrl_DIV) begin
          state_d = PREP;
          op_d    = ctrl_DIV ? OP_DIV : OP_MULT;
          a_d     = data_operandA;
          b_d     = data_operandB;
        end
      end
      PREP: begin
        sign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        b_d    = b_abs;
        cnt_d  = '0;
        dz_d   = 1'b0;
        if (op_q == OP_MULT) begin
          mcand_d = {{WIDTH{1'b0}}, a_abs};
          acc_d   = '0;
        end else begin
          mcand_d = '0;
          acc_d   = {{WIDTH{1'b0}}, a_abs};
        end
        if (op_q == OP_DIV && b_q == '0) begin
          dz_d    = 1'b1;
          state_d = FIX;
`ifdef MULTDIV_EARLY_TERM_EN
        end else if (b_q == '0) begin
          state_d = FIX;
`endif
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = step_acc;
        mcand_d = step_mcand;
        b_d     = step_b;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
`ifdef MULTDIV_EARLY_TERM_EN
        if (op_q == OP_MULT && step_b == '0) state_d = FIX;
`endif
      end
      FIX: begin
        res_d   = fix_res;
        exc_d   = fix_exc;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a result scoreboard.
// Latency expectations follow MULTDIV_EARLY_TERM_EN when defined.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  multdiv_sequencer #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] b);
`ifdef MULTDIV_EARLY_TERM_EN
    logic [31:0] m;
    int k;
    m = b[31] ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return 2 + k;
`else
    return 34;
`endif
  endfunction

  task automatic run_op(input string tag, input bit is_div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input bit e, input int lat);
    int n;
    bit got;
    bit busy_ok;
    exp_t x;
    @(negedge clock);
    ctrl_MULT = !is_div;
    ctrl_DIV  = is_div;
    data_operandA = a;
    data_operandB = b;
    sb.push_back('{r, e, lat});
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    busy_ok = busy;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clock);
      n++;
      #1;
      if (data_resultRDY) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (!got && n == 5) begin
        ctrl_MULT = 1'b1;
        data_operandA = 32'd99;
      end
      if (n == 6) ctrl_MULT = 1'b0;
    end
    ctrl_MULT = 1'b0;
    check({tag, " ready"}, 32'(got), 32'd1);
    if (got) begin
      x = sb.pop_front();
      check({tag, " result"}, data_result, x.res);
      check({tag, " exc"}, 32'(data_exception), 32'(x.exc));
      check({tag, " latency"}, n, x.lat);
      check({tag, " busy_done"}, 32'(busy), 32'd1);
    end
    check({tag, " busy_run"}, 32'(busy_ok), 32'd1);
    @(posedge clock);
    #1;
    check({tag, " rdy_pulse"}, 32'(data_resultRDY), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    #1;
    check("rst result", data_result, 32'd0);
    check("rst exc", 32'(data_exception), 32'd0);
    check("rst rdy", 32'(data_resultRDY), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("m7x-3", 0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 0, mul_lat(-32'sd3));
    run_op("m2^16sq", 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1,
           mul_lat(32'h0001_0000));
    run_op("mmin_x1", 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0,
           mul_lat(32'd1));
    run_op("m5x3", 0, 32'd5, 32'd3, 32'd15, 0, mul_lat(32'd3));
    run_op("m5x0", 0, 32'd5, 32'd0, 32'd0, 0, mul_lat(32'd0));
    run_op("m-4x-5", 0, -32'sd4, -32'sd5, 32'd20, 0, mul_lat(-32'sd5));
    run_op("mmax_x2", 0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1,
           mul_lat(32'd2));
    run_op("mneg_edge", 0, 32'hFFFF_8000, 32'h0001_0000, 32'h8000_0000, 0,
           mul_lat(32'h0001_0000));
    run_op("d100/7", 1, 32'd100, 32'd7, 32'd14, 0, 34);
    run_op("d3/10", 1, 32'd3, 32'd10, 32'd0, 0, 34);
    run_op("dmin/1", 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 34);
    run_op("dmin/min", 1, 32'h8000_0000, 32'h8000_0000, 32'd1, 0, 34);
    run_op("d5/0", 1, 32'd5, 32'd0, 32'd0, 1, 2);
    run_op("dmin/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34);
    run_op("d-7/2", 1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0, 34);

    @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      if (busy || data_resultRDY) seen = 1'b1;
    end
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_high idle", 32'(seen), 32'd0);

    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("abort busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort result", data_result, 32'd0);
    check("abort exc", 32'(data_exception), 32'd0);
    check("abort rdy", 32'(data_resultRDY), 32'd0);
    check("abort busy0", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) seen = 1'b1;
    end
    check("abort no_rdy", 32'(seen), 32'd0);

    run_op("m6x6", 0, 32'd6, 32'd6, 32'd36, 0, mul_lat(32'd6));

    check("sb empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
